// File: rtl/tinker_regfile_sb.sv
// Register file with combinational read ports, one writeback port and a write-pending
// scoreboard used by decode to detect RAW/WAW hazards.
module tinker_regfile_sb #(
    parameter int unsigned          DATA_W   = 64,
    parameter int unsigned          NUM_REGS = 32,
    parameter int unsigned          NUM_RD   = 3,
    parameter int unsigned          SP_REG   = 31,
    parameter logic [DATA_W-1:0]    SP_RESET = 'h80000,
    parameter int unsigned          BYPASS   = 1,
    parameter int unsigned          AW       = 5,
    localparam int unsigned         CW       = $clog2(NUM_REGS + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_pending_o,
    input  logic                     issue_valid_i,
    input  logic [AW-1:0]            issue_dst_i,
    output logic                     issue_ready_o,
    input  logic                     wb_valid_i,
    input  logic [AW-1:0]            wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     flush_i,
    output logic [DATA_W-1:0]        sp_out_o,
    output logic [CW-1:0]            pending_count_o
);

    localparam int unsigned IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AW:0] NumRegsW   = (AW + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic          wb_ok, iss_ok, issue_acc, cnt_inc, cnt_dec;
    logic [IW-1:0] wb_idx, iss_idx;

    assign wb_idx  = wb_addr_i[IW-1:0];
    assign iss_idx = issue_dst_i[IW-1:0];
    assign wb_ok   = wb_valid_i && ({1'b0, wb_addr_i} < NumRegsW);
    assign iss_ok  = {1'b0, issue_dst_i} < NumRegsW;

    // A writeback landing this cycle frees the destination, so re-issue is allowed.
    assign issue_ready_o = !flush_i && iss_ok &&
                           (!pend_q[iss_idx] || (wb_valid_i && (wb_addr_i == issue_dst_i)));
    assign issue_acc     = issue_valid_i && issue_ready_o;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_ok, byp;
        assign ra    = rd_addr_i[g*AW +: AW];
        assign ra_ok = {1'b0, ra} < NumRegsW;
        assign byp   = (BYPASS != 0) && wb_valid_i && (wb_addr_i == ra);
        assign rd_data_o[g*DATA_W +: DATA_W] = !ra_ok ? '0 :
                                               byp    ? wb_data_i : regs_q[ra[IW-1:0]];
        assign rd_pending_o[g] = ra_ok && !byp && pend_q[ra[IW-1:0]];
    end

    always_comb begin
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        cnt_inc = 1'b0;
        cnt_dec = 1'b0;
        if (flush_i) begin
            pend_d = '0;
            cnt_d  = '0;
        end else begin
            if (wb_ok) begin
                pend_d[wb_idx] = 1'b0;
            end
            // Issue is applied after writeback so a same-register collision keeps the bit set.
            if (issue_acc) begin
                pend_d[iss_idx] = 1'b1;
            end
            cnt_inc = issue_acc && !pend_q[iss_idx];
            cnt_dec = wb_ok && pend_q[wb_idx] && !(issue_acc && (iss_idx == wb_idx));
            cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_REG) ? SP_RESET : '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wb_ok) begin
                regs_q[wb_idx] <= wb_data_i;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sp_out_o        = regs_q[SP_REG];
    assign pending_count_o = cnt_q;

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Drives two register-file configurations (32 regs with bypass, 24 regs without) from one
// stimulus stream and compares both against an array-based reference model.
module tb_tinker_regfile_sb;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 5;
    localparam int unsigned NRD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [NRD*AW-1:0]  rd_addr;
    logic               iv, wv, flush;
    logic [AW-1:0]      idst, wa;
    logic [DW-1:0]      wd;

    logic [NRD*DW-1:0]  rdd_a, rdd_b;
    logic [NRD-1:0]     rdp_a, rdp_b;
    logic               rdy_a, rdy_b;
    logic [DW-1:0]      sp_a, sp_b;
    logic [5:0]         cnt_a;
    logic [4:0]         cnt_b;

    tinker_regfile_sb #(
        .DATA_W(64), .NUM_REGS(32), .NUM_RD(3), .SP_REG(31), .BYPASS(1), .AW(5)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdd_a),
        .rd_pending_o(rdp_a), .issue_valid_i(iv), .issue_dst_i(idst), .issue_ready_o(rdy_a),
        .wb_valid_i(wv), .wb_addr_i(wa), .wb_data_i(wd), .flush_i(flush),
        .sp_out_o(sp_a), .pending_count_o(cnt_a)
    );

    tinker_regfile_sb #(
        .DATA_W(64), .NUM_REGS(24), .NUM_RD(3), .SP_REG(20), .BYPASS(0), .AW(5)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdd_b),
        .rd_pending_o(rdp_b), .issue_valid_i(iv), .issue_dst_i(idst), .issue_ready_o(rdy_b),
        .wb_valid_i(wv), .wb_addr_i(wa), .wb_data_i(wd), .flush_i(flush),
        .sp_out_o(sp_b), .pending_count_o(cnt_b)
    );

    int unsigned nr  [2] = '{32, 24};
    bit          byp [2] = '{1'b1, 1'b0};
    int unsigned spr [2] = '{31, 20};
    logic [63:0] m_regs [2][64];
    bit          m_pend [2][64];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] e_data(input int k, input int a);
        if (a >= int'(nr[k])) return 64'd0;
        if (byp[k] && wv && (int'(wa) == a)) return wd;
        return m_regs[k][a];
    endfunction

    function automatic bit e_pend(input int k, input int a);
        if (a >= int'(nr[k])) return 1'b0;
        if (byp[k] && wv && (int'(wa) == a)) return 1'b0;
        return m_pend[k][a];
    endfunction

    function automatic bit e_ready(input int k);
        if (flush || idst >= nr[k]) return 1'b0;
        return !m_pend[k][idst] || (wv && wa == idst);
    endfunction

    function automatic int e_count(input int k);
        int n = 0;
        for (int r = 0; r < 64; r++) n += int'(m_pend[k][r]);
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 64; r++) begin
                m_regs[k][r] = 64'd0;
                m_pend[k][r] = 1'b0;
            end
            m_regs[k][spr[k]] = 64'h80000;
        end
    endtask

    task automatic model_edge();
        bit acc;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            acc = iv && e_ready(k);
            if (wv && wa < nr[k]) m_regs[k][wa] = wd;
            if (flush) begin
                for (int r = 0; r < 64; r++) m_pend[k][r] = 1'b0;
            end else begin
                if (wv && wa < nr[k]) m_pend[k][wa] = 1'b0;
                if (acc) m_pend[k][idst] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [NRD*DW-1:0] d;
        logic [NRD-1:0]    p;
        logic [NRD-1:0]    ep;
        int                a;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? rdd_a : rdd_b;
            p = (k == 0) ? rdp_a : rdp_b;
            for (int i = 0; i < int'(NRD); i++) begin
                a = int'(rd_addr[i*AW +: AW]);
                chk($sformatf("i%0d rd_data%0d a%0d", k, i, a), d[i*DW +: DW], e_data(k, a));
                ep[i] = e_pend(k, a);
            end
            chk($sformatf("i%0d rd_pending", k), 64'(p), 64'(ep));
            chk($sformatf("i%0d issue_ready", k), 64'((k == 0) ? rdy_a : rdy_b), 64'(e_ready(k)));
            chk($sformatf("i%0d sp_out", k), (k == 0) ? sp_a : sp_b, m_regs[k][spr[k]]);
            chk($sformatf("i%0d pending_count", k), (k == 0) ? 64'(cnt_a) : 64'(cnt_b),
                64'(e_count(k)));
        end
    endtask

    task automatic step();
        #3;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        iv = 1'b0; wv = 1'b0; flush = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_rd(0, 1, 2);
        idst = 5'd3; wa = '0; wd = '0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        for (int a = 0; a < 31; a += 3) begin
            set_rd(a, a + 1, (a + 2 > 30) ? 30 : a + 2);
            step();
        end

        // Same-cycle writeback visible on instance A only.
        set_rd(5, 5, 0);
        wv = 1'b1; wa = 5'd5; wd = 64'hDEAD;
        #1;
        chk("bypass A", rdd_a[63:0], 64'hDEAD);
        chk("no bypass B", rdd_b[63:0], 64'h0);
        step();
        idle();
        #1;
        chk("after wb B", rdd_b[63:0], 64'hDEAD);
        step();

        // Scoreboard on r7.
        set_rd(7, 7, 5);
        iv = 1'b1; idst = 5'd7;
        step();
        #1;
        chk("r7 pending", 64'(rdp_a[0]), 64'd1);
        chk("r7 reissue", 64'(rdy_a), 64'd0);
        chk("count one", 64'(cnt_a), 64'd1);
        step();
        idle();
        wv = 1'b1; wa = 5'd7; wd = 64'h12;
        step();
        idle();
        #1;
        chk("r7 data", rdd_b[63:0], 64'h12);
        chk("count zero", 64'(cnt_b), 64'd0);
        step();

        // Collision on r9.
        set_rd(9, 9, 9);
        iv = 1'b1; idst = 5'd9;
        step();
        wv = 1'b1; wa = 5'd9; wd = 64'h44;
        step();
        idle();
        step();

        // Flush.
        for (int r = 1; r <= 3; r++) begin
            iv = 1'b1; idst = 5'(r);
            step();
        end
        set_rd(2, 4, 1);
        iv = 1'b1; idst = 5'd4; wv = 1'b1; wa = 5'd2; wd = 64'h7; flush = 1'b1;
        #1;
        chk("flush blocks", 64'(rdy_a), 64'd0);
        step();
        idle();
        #1;
        chk("flush count", 64'(cnt_a), 64'd0);
        step();

        // Bounds on the 24-entry instance.
        iv = 1'b1; idst = 5'd30; set_rd(25, 28, 23);
        step();
        idle();
        wv = 1'b1; wa = 5'd28; wd = 64'hBAD;
        step();
        idle();
        step();

        // Mid-cycle reset discards an in-flight writeback.
        set_rd(8, 31, 20);
        wv = 1'b1; wa = 5'd8; wd = 64'h1234;
        iv = 1'b1; idst = 5'd8;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset sp A", sp_a, 64'h80000);
        chk("reset count A", 64'(cnt_a), 64'd0);
        step();
        rst_n = 1'b1;
        idle();
        idst = 5'd3;
        step();

        for (int n = 0; n < 400; n++) begin
            set_rd($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            iv    = ($urandom_range(0, 2) != 0);
            idst  = 5'($urandom_range(0, 31));
            wv    = ($urandom_range(0, 1) != 0);
            wa    = 5'($urandom_range(0, 31));
            wd    = {$urandom, $urandom};
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
